// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer: mode encodings, register map,
// control/command bit positions and the readback byte selector.
package multi_timer_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE  = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_PWM     = 2'd2,
        MODE_PULSE   = 2'd3
    } mode_e;

    localparam logic [3:0] REG_PERIOD0 = 4'h0;
    localparam logic [3:0] REG_DUTY0   = 4'h4;
    localparam logic [3:0] REG_CTRL    = 4'h8;
    localparam logic [3:0] REG_CMD     = 4'h9;
    localparam logic [3:0] REG_STATUS  = 4'hA;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_INV      = 3;
    localparam int CTRL_IRQ      = 4;

    localparam int CMD_RESTART   = 0;
    localparam int CMD_CLR_DONE  = 1;

    localparam logic [6:0] ID_ADDR  = 7'h7F;
    localparam logic [7:0] ID_VALUE = 8'h5B;

    // Little-endian byte idx of a zero-extended register value.
    function automatic logic [7:0] byte_sel(input logic [31:0] value, input logic [1:0] idx);
        logic [31:0] shifted;
        shifted = value >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: its register bank, active period/duty copies, counter
// and the four output modes.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [3:0]       reg_addr,
    input  logic [7:0]       wdata,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] duty,
    output logic [4:0]       ctrl,
    output logic             out,
    output logic             done,
    output logic             timer_out
);

    logic [CNT_W-1:0] period_r, duty_r, period_act_r, duty_act_r, cnt_r;
    logic [4:0]       ctrl_r;
    logic             out_r, done_r, held_r, timer_out_r;

    logic [CNT_W-1:0] cnt_n_s;
    logic             out_n_s, held_n_s, set_done_s, load_act_s;
    logic             enable_s, tc_s, restart_s, clear_s;
    mode_e            mode_s;

    // Bytes beyond CNT_W fall off the top when the wide value is truncated.
    function automatic logic [CNT_W-1:0] write_byte(input logic [CNT_W-1:0] old,
                                                    input logic [1:0] idx,
                                                    input logic [7:0] data);
        logic [31:0] wide;
        wide = 32'(old);
        wide[{idx, 3'b000} +: 8] = data;
        return wide[CNT_W-1:0];
    endfunction

    assign enable_s  = ctrl_r[CTRL_EN];
    assign mode_s    = mode_e'(ctrl_r[CTRL_MODE_LSB +: 2]);
    assign tc_s      = (cnt_r == period_act_r);
    assign restart_s = wr && (reg_addr == REG_CMD) && wdata[CMD_RESTART];
    assign clear_s   = wr && (reg_addr == REG_CMD) && wdata[CMD_CLR_DONE];

    // Next counter/output state; held_r marks a one-shot that already fired.
    always_comb begin
        cnt_n_s    = cnt_r;
        out_n_s    = out_r;
        held_n_s   = held_r;
        set_done_s = 1'b0;
        load_act_s = 1'b0;
        if (!enable_s || restart_s) begin
            cnt_n_s    = '0;
            out_n_s    = 1'b0;
            held_n_s   = 1'b0;
            load_act_s = 1'b1;
        end else begin
            cnt_n_s    = tc_s ? '0 : cnt_r + CNT_W'(1);
            set_done_s = tc_s;
            load_act_s = tc_s;
            held_n_s   = 1'b0;
            case (mode_s)
                MODE_SQUARE:  out_n_s = tc_s ? ~out_r : out_r;
                MODE_ONESHOT: begin
                    if (held_r || tc_s) begin
                        cnt_n_s    = cnt_r;
                        out_n_s    = 1'b1;
                        held_n_s   = 1'b1;
                        set_done_s = !held_r;
                    end else begin
                        out_n_s = 1'b0;
                    end
                end
                MODE_PWM:     out_n_s = (cnt_r < duty_act_r);
                MODE_PULSE:   out_n_s = tc_s;
                default:      out_n_s = out_r;
            endcase
        end
    end

    // Register bank, active copies and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r     <= '0;
            duty_r       <= '0;
            ctrl_r       <= 5'd0;
            period_act_r <= '0;
            duty_act_r   <= '0;
            cnt_r        <= '0;
            out_r        <= 1'b0;
            held_r       <= 1'b0;
            done_r       <= 1'b0;
            timer_out_r  <= 1'b0;
        end else begin
            if (wr) begin
                case (reg_addr)
                    REG_PERIOD0, REG_PERIOD0 + 4'd1, REG_PERIOD0 + 4'd2, REG_PERIOD0 + 4'd3:
                        period_r <= write_byte(period_r, reg_addr[1:0], wdata);
                    REG_DUTY0, REG_DUTY0 + 4'd1, REG_DUTY0 + 4'd2, REG_DUTY0 + 4'd3:
                        duty_r <= write_byte(duty_r, reg_addr[1:0], wdata);
                    REG_CTRL: ctrl_r <= wdata[4:0];
                    default:  ;
                endcase
            end
            if (load_act_s) begin
                period_act_r <= period_r;
                duty_act_r   <= duty_r;
            end
            cnt_r       <= cnt_n_s;
            out_r       <= out_n_s;
            held_r      <= held_n_s;
            done_r      <= set_done_s ? 1'b1 : (clear_s ? 1'b0 : done_r);
            timer_out_r <= out_n_s ^ ctrl_r[CTRL_INV];
        end
    end

    assign period    = period_r;
    assign duty      = duty_r;
    assign ctrl      = ctrl_r;
    assign out       = out_r;
    assign done      = done_r;
    assign timer_out = timer_out_r;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: address decode, combinational readback mux and
// registered interrupt OR over all channels.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24
) (
    input  logic              CORE_CLK,
    input  logic              RST,
    input  logic [6:0]        ADDRESS,
    input  logic [7:0]        DATA_IN,
    input  logic              STROBE_WR,
    output logic [7:0]        DATA_OUT,
    output logic [NUM_CH-1:0] TIMER_OUT,
    output logic              IRQ
);

    logic [2:0]       ch_s;
    logic [3:0]       reg_s;
    logic             ch_valid_s, irq_any_s, irq_r, sel_out_s, sel_done_s;
    logic [NUM_CH-1:0] wr_s;
    logic [CNT_W-1:0] period_s [NUM_CH];
    logic [CNT_W-1:0] duty_s   [NUM_CH];
    logic [4:0]       ctrl_s   [NUM_CH];
    logic [NUM_CH-1:0] out_s, done_s;
    logic [31:0]      sel_period_s, sel_duty_s;
    logic [4:0]       sel_ctrl_s;

    assign ch_s       = ADDRESS[6:4];
    assign reg_s      = ADDRESS[3:0];
    assign ch_valid_s = ({1'b0, ch_s} < 4'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (CORE_CLK),
            .rst      (RST),
            .wr       (wr_s[g]),
            .reg_addr (reg_s),
            .wdata    (DATA_IN),
            .period   (period_s[g]),
            .duty     (duty_s[g]),
            .ctrl     (ctrl_s[g]),
            .out      (out_s[g]),
            .done     (done_s[g]),
            .timer_out(TIMER_OUT[g])
        );
    end

    // Per-channel write enables, selected-channel fields and interrupt OR.
    always_comb begin
        sel_period_s = 32'd0;
        sel_duty_s   = 32'd0;
        sel_ctrl_s   = 5'd0;
        sel_out_s    = 1'b0;
        sel_done_s   = 1'b0;
        irq_any_s    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_s[i]      = STROBE_WR && (ADDRESS != ID_ADDR) && (ch_s == 3'(i));
            sel_period_s = sel_period_s | ((ch_s == 3'(i)) ? 32'(period_s[i]) : 32'd0);
            sel_duty_s   = sel_duty_s   | ((ch_s == 3'(i)) ? 32'(duty_s[i])   : 32'd0);
            sel_ctrl_s   = sel_ctrl_s   | ((ch_s == 3'(i)) ? ctrl_s[i]        : 5'd0);
            sel_out_s    = sel_out_s    | ((ch_s == 3'(i)) && out_s[i]);
            sel_done_s   = sel_done_s   | ((ch_s == 3'(i)) && done_s[i]);
            irq_any_s    = irq_any_s    | (done_s[i] && ctrl_s[i][CTRL_IRQ]);
        end
    end

    // Readback mux; CMD is write-only and reads as zero.
    always_comb begin
        DATA_OUT = 8'h00;
        if (ADDRESS == ID_ADDR) begin
            DATA_OUT = ID_VALUE;
        end else if (ch_valid_s) begin
            case (reg_s)
                REG_PERIOD0, REG_PERIOD0 + 4'd1, REG_PERIOD0 + 4'd2, REG_PERIOD0 + 4'd3:
                    DATA_OUT = byte_sel(sel_period_s, reg_s[1:0]);
                REG_DUTY0, REG_DUTY0 + 4'd1, REG_DUTY0 + 4'd2, REG_DUTY0 + 4'd3:
                    DATA_OUT = byte_sel(sel_duty_s, reg_s[1:0]);
                REG_CTRL:   DATA_OUT = {3'b000, sel_ctrl_s};
                REG_STATUS: DATA_OUT = {6'b000000, sel_done_s, sel_out_s};
                default:    DATA_OUT = 8'h00;
            endcase
        end else begin
            DATA_OUT = 8'h00;
        end
    end

    // Interrupt follows the channel done/irq_en OR by one cycle.
    always_ff @(posedge CORE_CLK) begin
        if (RST) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_any_s;
        end
    end

    assign IRQ = irq_r;

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for multi_timer with hand-computed expectations.
module tb_multi_timer;

    logic       CORE_CLK;
    logic       RST;
    logic [6:0] ADDRESS;
    logic [7:0] DATA_IN;
    logic       STROBE_WR;
    logic [7:0] DATA_OUT;
    logic [3:0] TIMER_OUT;
    logic       IRQ;

    int test_cnt = 0;
    int fail_cnt = 0;
    int hi;

    multi_timer #(.NUM_CH(4), .CNT_W(24)) dut (
        .CORE_CLK (CORE_CLK),
        .RST      (RST),
        .ADDRESS  (ADDRESS),
        .DATA_IN  (DATA_IN),
        .STROBE_WR(STROBE_WR),
        .DATA_OUT (DATA_OUT),
        .TIMER_OUT(TIMER_OUT),
        .IRQ      (IRQ)
    );

    initial CORE_CLK = 1'b0;
    always #5 CORE_CLK = ~CORE_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CORE_CLK);
    endtask

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        ADDRESS   = a;
        DATA_IN   = d;
        STROBE_WR = 1'b1;
        @(negedge CORE_CLK);
        STROBE_WR = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
        ADDRESS = a;
        #1;
        check(tag, {24'd0, DATA_OUT}, {24'd0, exp});
    endtask

    task automatic count_hi(input int bit_idx, input int n);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CORE_CLK);
            hi += int'(TIMER_OUT[bit_idx]);
        end
    endtask

    initial begin
        RST = 1'b1; ADDRESS = 7'h00; DATA_IN = 8'h00; STROBE_WR = 1'b0;
        tick(3);
        check("rst_timer_out", 32'(TIMER_OUT), 32'd0);
        check("rst_irq", 32'(IRQ), 32'd0);
        chk_rd("rst_id", 7'h7F, 8'h5B);
        ADDRESS = 7'h00;
        RST = 1'b0;
        wr(7'h00, 8'h09);
        chk_rd("first_write", 7'h00, 8'h09);

        // Ch0 square wave, P=9
        wr(7'h08, 8'h01);
        tick(9);  check("sq_n9",  32'(TIMER_OUT[0]), 32'd0);
        tick(1);  check("sq_n10", 32'(TIMER_OUT[0]), 32'd1);
        chk_rd("sq_status", 7'h0A, 8'h03);
        tick(9);  check("sq_n19", 32'(TIMER_OUT[0]), 32'd1);
        tick(1);  check("sq_n20", 32'(TIMER_OUT[0]), 32'd0);
        tick(10); check("sq_n30", 32'(TIMER_OUT[0]), 32'd1);
        wr(7'h08, 8'h00);

        // Ch1 PWM, P=99, duty 25 / 0 / 200
        wr(7'h10, 8'h63);
        wr(7'h14, 8'h19);
        chk_rd("duty_rd", 7'h14, 8'h19);
        wr(7'h18, 8'h05);
        count_hi(1, 100);
        check("pwm25_count", 32'(hi), 32'd25);
        check("pwm25_n100", 32'(TIMER_OUT[1]), 32'd0);
        tick(1); check("pwm25_n101", 32'(TIMER_OUT[1]), 32'd1);
        wr(7'h14, 8'h00);
        tick(150); count_hi(1, 100);
        check("pwm0_count", 32'(hi), 32'd0);
        wr(7'h14, 8'hC8);
        tick(150); count_hi(1, 100);
        check("pwm200_count", 32'(hi), 32'd100);
        wr(7'h18, 8'h00);

        // Ch2 one-shot, P=50, irq_en
        wr(7'h20, 8'h32);
        wr(7'h28, 8'h13);
        tick(50);
        check("os_n50_out", 32'(TIMER_OUT[2]), 32'd0);
        check("os_n50_irq", 32'(IRQ), 32'd0);
        tick(1);
        check("os_n51_out", 32'(TIMER_OUT[2]), 32'd1);
        check("os_n51_irq", 32'(IRQ), 32'd0);
        tick(1);
        check("os_n52_irq", 32'(IRQ), 32'd1);
        chk_rd("os_status", 7'h2A, 8'h03);
        tick(20); check("os_hold", 32'(TIMER_OUT[2]), 32'd1);
        wr(7'h29, 8'h02);
        tick(1); check("os_clr_irq", 32'(IRQ), 32'd0);
        chk_rd("os_clr_status", 7'h2A, 8'h01);
        wr(7'h29, 8'h01);
        check("os_restart_out", 32'(TIMER_OUT[2]), 32'd0);
        tick(50); check("os_r50_out", 32'(TIMER_OUT[2]), 32'd0);
        tick(1);  check("os_r51_out", 32'(TIMER_OUT[2]), 32'd1);
        tick(1);  check("os_r52_irq", 32'(IRQ), 32'd1);
        wr(7'h28, 8'h00);
        wr(7'h29, 8'h02);

        // Ch3 square, P=9 then PERIOD=4 written mid-period
        wr(7'h30, 8'h09);
        wr(7'h38, 8'h01);
        tick(3);
        wr(7'h30, 8'h04);
        tick(5); check("mid_n9",  32'(TIMER_OUT[3]), 32'd0);
        tick(1); check("mid_n10", 32'(TIMER_OUT[3]), 32'd1);
        tick(4); check("mid_n14", 32'(TIMER_OUT[3]), 32'd1);
        tick(1); check("mid_n15", 32'(TIMER_OUT[3]), 32'd0);
        tick(4); check("mid_n19", 32'(TIMER_OUT[3]), 32'd0);
        tick(1); check("mid_n20", 32'(TIMER_OUT[3]), 32'd1);

        // Reset in the middle of activity on every channel
        wr(7'h08, 8'h01);
        wr(7'h18, 8'h05);
        wr(7'h28, 8'h13);
        tick(60);
        check("pre_rst_irq", 32'(IRQ), 32'd1);
        check("pre_rst_pwm", 32'(TIMER_OUT[1]), 32'd1);
        RST = 1'b1;
        tick(1);
        check("midrst_out", 32'(TIMER_OUT), 32'd0);
        check("midrst_irq", 32'(IRQ), 32'd0);
        tick(2);
        check("midrst_hold", 32'(TIMER_OUT), 32'd0);
        RST = 1'b0;
        chk_rd("midrst_id", 7'h7F, 8'h5B);
        chk_rd("midrst_st0", 7'h0A, 8'h00);
        chk_rd("midrst_st1", 7'h1A, 8'h00);
        chk_rd("midrst_st2", 7'h2A, 8'h00);
        chk_rd("midrst_st3", 7'h3A, 8'h00);
        tick(25);
        check("postrst_out", 32'(TIMER_OUT), 32'd0);
        check("postrst_irq", 32'(IRQ), 32'd0);

        // Ch3 pulse, P=3; clear_done on a TC edge must leave done set
        wr(7'h30, 8'h03);
        wr(7'h38, 8'h07);
        chk_rd("ctrl_rd", 7'h38, 8'h07);
        tick(3); check("pl_n3", 32'(TIMER_OUT[3]), 32'd0);
        tick(1); check("pl_n4", 32'(TIMER_OUT[3]), 32'd1);
        tick(1); check("pl_n5", 32'(TIMER_OUT[3]), 32'd0);
        tick(3); check("pl_n8", 32'(TIMER_OUT[3]), 32'd1);
        wr(7'h39, 8'h02);
        chk_rd("pl_clr_status", 7'h3A, 8'h00);
        tick(2);
        wr(7'h39, 8'h02);
        chk_rd("pl_tc_clr_status", 7'h3A, 8'h03);
        tick(3); check("pl_n15", 32'(TIMER_OUT[3]), 32'd0);
        tick(1); check("pl_n16", 32'(TIMER_OUT[3]), 32'd1);

        // Register map boundaries
        wr(7'h02, 8'h12);
        chk_rd("byte2_rd", 7'h02, 8'h12);
        wr(7'h03, 8'hAB);
        chk_rd("byte3_ignored", 7'h03, 8'h00);
        wr(7'h40, 8'hFF);
        chk_rd("bad_ch_rd", 7'h40, 8'h00);
        chk_rd("unmapped_rd", 7'h0B, 8'h00);
        chk_rd("cmd_rd", 7'h39, 8'h00);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
